// File: rtl/imem_pkg.sv
// imem_pkg: shared types and default sizes for the instruction memory port arbiter.
// Used by imem_port_arbiter and imem_wait_counter.
package imem_pkg;

    localparam int ADDR_W_DEF   = 12;
    localparam int DATA_W_DEF   = 19;
    localparam int MAX_WAIT_DEF = 4;
    localparam int STAT_W       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        BURST = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LOAD  = 1'b1
    } owner_t;

endpackage

// File: rtl/imem_wait_counter.sv
// imem_wait_counter: counts consecutive denied cycles of one requester, saturating at MAX_WAIT.
// at_max flags that the requester is owed a forced grant.
module imem_wait_counter
    import imem_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic at_max
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAXV = CW'(MAX_WAIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!req || gnt) begin
            cnt <= '0;
        end else if (cnt != MAXV) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign at_max = (cnt == MAXV);

endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: per-cycle arbiter sharing the instruction memory between fetch and loader.
// Define IMEM_ARB_STATS_EN to add the stat_conflicts / stat_forced counters.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              load_req,
    input  logic              load_we,
    input  logic              load_lock,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_wdata,
    output logic              load_gnt,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef IMEM_ARB_STATS_EN
    output logic [STAT_W-1:0] stat_conflicts,
    output logic [STAT_W-1:0] stat_forced,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state_q, state_d;
    owner_t     rr_last_q, rr_last_d;
    owner_t     owner_q;
    logic       valid_q;
    logic       we_q;
    logic       f_max, l_max;
    logic       gnt_f, gnt_l, forced;

    imem_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_fetch (
        .clk    (clk),
        .rst    (rst),
        .req    (fetch_req),
        .gnt    (gnt_f),
        .at_max (f_max)
    );

    imem_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_load (
        .clk    (clk),
        .rst    (rst),
        .req    (load_req),
        .gnt    (gnt_l),
        .at_max (l_max)
    );

    // Starvation relief outranks burst ownership and round-robin.
    always_comb begin
        gnt_f  = 1'b0;
        gnt_l  = 1'b0;
        forced = 1'b0;
        if (fetch_req && f_max) begin
            gnt_f  = 1'b1;
            forced = 1'b1;
        end else if (load_req && l_max) begin
            gnt_l  = 1'b1;
            forced = 1'b1;
        end else if (state_q == BURST && load_lock && load_req) begin
            gnt_l = 1'b1;
        end else if (fetch_req && load_req) begin
            if (rr_last_q == OWN_LOAD) begin
                gnt_f = 1'b1;
            end else begin
                gnt_l = 1'b1;
            end
        end else if (fetch_req) begin
            gnt_f = 1'b1;
        end else if (load_req) begin
            gnt_l = 1'b1;
        end
        if (rst) begin
            gnt_f  = 1'b0;
            gnt_l  = 1'b0;
            forced = 1'b0;
        end
    end

    always_comb begin
        state_d   = IDLE;
        rr_last_d = rr_last_q;
        if (gnt_f) begin
            state_d   = FETCH;
            rr_last_d = OWN_FETCH;
        end else if (gnt_l) begin
            state_d   = load_lock ? BURST : LOAD;
            rr_last_d = OWN_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_last_q <= OWN_LOAD;
            owner_q   <= OWN_FETCH;
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            owner_q   <= gnt_l ? OWN_LOAD : OWN_FETCH;
            valid_q   <= gnt_f | gnt_l;
            we_q      <= gnt_l & load_we;
        end
    end

    always_comb begin
        fetch_gnt   = gnt_f;
        load_gnt    = gnt_l;
        mem_addr    = '0;
        if (gnt_f) begin
            mem_addr = fetch_addr;
        end else if (gnt_l) begin
            mem_addr = load_addr;
        end
        mem_we      = gnt_l & load_we;
        mem_wdata   = (gnt_l & load_we) ? load_wdata : '0;
        fetch_valid = valid_q && (owner_q == OWN_FETCH) && !rst;
        load_valid  = valid_q && (owner_q == OWN_LOAD) && !rst;
        fetch_data  = fetch_valid ? mem_rdata : '0;
        // A write ack carries no data.
        load_rdata  = (load_valid && !we_q) ? mem_rdata : '0;
    end

`ifdef IMEM_ARB_STATS_EN
    logic [STAT_W-1:0] conf_q, forced_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conf_q   <= '0;
            forced_q <= '0;
        end else begin
            if (fetch_req && load_req && conf_q != '1) begin
                conf_q <= conf_q + STAT_W'(1);
            end
            if (forced && forced_q != '1) begin
                forced_q <= forced_q + STAT_W'(1);
            end
        end
    end

    assign stat_conflicts = rst ? '0 : conf_q;
    assign stat_forced    = rst ? '0 : forced_q;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed scenarios plus random traffic against a rule-level model.
// Define IMEM_ARB_STATS_EN to also check the statistics counters.
module tb_imem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 19;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          load_req;
    logic          load_we;
    logic          load_lock;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_wdata;
    logic          load_gnt;
    logic          load_valid;
    logic [DW-1:0] load_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef IMEM_ARB_STATS_EN
    logic [15:0]   stat_conflicts;
    logic [15:0]   stat_forced;
`endif

    always #5 clk = ~clk;

    imem_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_gnt      (fetch_gnt),
        .fetch_valid    (fetch_valid),
        .fetch_data     (fetch_data),
        .load_req       (load_req),
        .load_we        (load_we),
        .load_lock      (load_lock),
        .load_addr      (load_addr),
        .load_wdata     (load_wdata),
        .load_gnt       (load_gnt),
        .load_valid     (load_valid),
        .load_rdata     (load_rdata),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
`ifdef IMEM_ARB_STATS_EN
        .stat_conflicts (stat_conflicts),
        .stat_forced    (stat_forced),
`endif
        .mem_rdata      (mem_rdata)
    );

    // Memory array with registered read, driven by the DUT.
    logic [DW-1:0] mem [0:4095];
    // Independent shadow of the memory contents kept by the model.
    logic [DW-1:0] ref_mem [0:4095];

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model state: denied-cycle counts, last winner, burst owner, pending response.
    int            wf, wl;
    bit            last_load;
    bit            burst;
    bit            pv, pown_l, pwe;
    logic [DW-1:0] pdata;
    int            s_conf, s_forced;
    bit            obs_fgnt;

    task automatic step(input bit r, input bit fr, input logic [AW-1:0] fa,
                        input bit lr, input bit lwe, input bit llk,
                        input logic [AW-1:0] la, input logic [DW-1:0] lwd);
        int            win;
        bit            frc;
        logic [AW-1:0] ea;
        bit            ewe;
        rst = r; fetch_req = fr; fetch_addr = fa;
        load_req = lr; load_we = lwe; load_lock = llk;
        load_addr = la; load_wdata = lwd;
        @(negedge clk);
        if (r) begin
            chk("rst_fgnt", 32'(fetch_gnt), 0);
            chk("rst_lgnt", 32'(load_gnt), 0);
            chk("rst_fval", 32'(fetch_valid), 0);
            chk("rst_lval", 32'(load_valid), 0);
            chk("rst_fdat", 32'(fetch_data), 0);
            chk("rst_ldat", 32'(load_rdata), 0);
            chk("rst_addr", 32'(mem_addr), 0);
            chk("rst_we", 32'(mem_we), 0);
            chk("rst_wdat", 32'(mem_wdata), 0);
`ifdef IMEM_ARB_STATS_EN
            chk("rst_sconf", 32'(stat_conflicts), 0);
            chk("rst_sforc", 32'(stat_forced), 0);
`endif
            wf = 0; wl = 0; last_load = 1; burst = 0; pv = 0;
            s_conf = 0; s_forced = 0;
        end else begin
            win = 0; frc = 0;
            if (fr && wf == MW) begin win = 1; frc = 1; end
            else if (lr && wl == MW) begin win = 2; frc = 1; end
            else if (burst && llk && lr) win = 2;
            else if (fr && lr) win = last_load ? 1 : 2;
            else if (fr) win = 1;
            else if (lr) win = 2;
            ea = (win == 1) ? fa : (win == 2) ? la : '0;
            ewe = (win == 2) && lwe;
            chk("fgnt", 32'(fetch_gnt), 32'(win == 1));
            chk("lgnt", 32'(load_gnt), 32'(win == 2));
            chk("addr", 32'(mem_addr), 32'(ea));
            chk("we", 32'(mem_we), 32'(ewe));
            if (ewe) chk("wdat", 32'(mem_wdata), 32'(lwd));
            chk("fval", 32'(fetch_valid), 32'(pv && !pown_l));
            chk("fdat", 32'(fetch_data), (pv && !pown_l) ? 32'(pdata) : 0);
            chk("lval", 32'(load_valid), 32'(pv && pown_l));
            chk("ldat", 32'(load_rdata), (pv && pown_l && !pwe) ? 32'(pdata) : 0);
`ifdef IMEM_ARB_STATS_EN
            chk("sconf", 32'(stat_conflicts), 32'(s_conf));
            chk("sforc", 32'(stat_forced), 32'(s_forced));
`endif
            pv = (win != 0);
            pown_l = (win == 2);
            pwe = ewe;
            pdata = ref_mem[ea];
            if (ewe) ref_mem[la] = lwd;
            wf = (fr && win != 1) ? ((wf < MW) ? wf + 1 : MW) : 0;
            wl = (lr && win != 2) ? ((wl < MW) ? wl + 1 : MW) : 0;
            if (win != 0) last_load = (win == 2);
            burst = (win == 2) && llk;
            if (fr && lr && s_conf < 65535) s_conf++;
            if (frc && s_forced < 65535) s_forced++;
        end
        obs_fgnt = fetch_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, 0, '0, '0);
    endtask

    initial begin
        logic [9:0] mask;
        bit         lk;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = DW'((i * 37 + 11) ^ (i << 7));
            ref_mem[i] = DW'((i * 37 + 11) ^ (i << 7));
        end
        wf = 0; wl = 0; last_load = 1; burst = 0;
        pv = 0; pown_l = 0; pwe = 0; pdata = '0;
        s_conf = 0; s_forced = 0;

        step(1, 0, '0, 0, 0, 0, '0, '0);
        step(1, 0, '0, 0, 0, 0, '0, '0);

        // Fetch stream 7, 8, 9
        step(0, 1, 12'd7, 0, 0, 0, '0, '0);
        step(0, 1, 12'd8, 0, 0, 0, '0, '0);
        step(0, 1, 12'd9, 0, 0, 0, '0, '0);
        idle();

        // Both requesting from fresh reset: alternation starting with fetch
        step(1, 0, '0, 0, 0, 0, '0, '0);
        step(0, 1, 12'd100, 1, 0, 0, 12'd200, '0);
        step(0, 1, 12'd101, 1, 0, 0, 12'd201, '0);
        step(0, 1, 12'd102, 1, 0, 0, 12'd202, '0);
        idle();

        // Loader write then read back
        step(0, 0, '0, 1, 1, 0, 12'd20, 19'h0F0F5);
        idle();
        step(0, 0, '0, 1, 0, 0, 12'd20, '0);
        idle();

        // Locked burst against a persistent fetch: forced grants at cycles 5 and 10
        step(1, 0, '0, 0, 0, 0, '0, '0);
        step(0, 1, 12'd1, 0, 0, 0, '0, '0);
        mask = '0;
        for (int c = 0; c < 10; c++) begin
            step(0, 1, AW'(300 + c), 1, 0, 1, AW'(400 + c), '0);
            mask[c] = obs_fgnt;
        end
        chk("t4_fgnt_mask", 32'(mask), 32'h210);
        idle();

        // Reset in the cycle after a loader read grant
        step(0, 0, '0, 1, 0, 0, 12'd33, '0);
        step(1, 0, '0, 0, 0, 0, '0, '0);
        idle();

        // Random traffic
        lk = 0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) lk = ~lk;
            step($urandom_range(0, 79) == 0,
                 $urandom_range(0, 3) != 0, AW'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, lk,
                 AW'($urandom_range(0, 63)), DW'($urandom));
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
